// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: floor, direction, door countdown, MSB digit first.
// Latency: outputs registered, 1 cycle after scan state; inputs sampled once per frame; no backpressure.
module fnd_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000,
    parameter int BLANK_CYC      = 2,
    parameter int BLINK_FRAMES   = 64,
    parameter int FLOOR_W        = 7,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLOOR_W-1:0]    floor_cur,
    input  logic [1:0]            dir,
    input  logic [3:0]            countdown,
    input  logic                  door_open,
    input  logic                  blink_en,
    output logic [NUM_DIGITS-1:0] fnd_com,
    output logic [7:0]            fnd_data,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W:0]        BLANK_LIM = (CNT_W + 1)'(BLANK_CYC);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]      BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] COM_OFF   = COM_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
    logic                  hide_q, hide_d;
    logic [FLOOR_W-1:0]    snap_floor_q;
    logic [1:0]            snap_dir_q;
    logic [3:0]            snap_cd_q;
    logic                  snap_door_q, snap_blink_q;
    logic [NUM_DIGITS-1:0] com_q, com_d, com_lo;
    logic [7:0]            data_q, data_d, glyph, cd_glyph;
    logic                  tick_q;
    logic                  slot_end, frame_end, blank;
    logic [31:0]           floor_val;
    logic [3:0]            tens, units;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h27;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == '0);
    assign blank     = ({1'b0, cnt_q} < BLANK_LIM);

    always_comb begin
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        blk_cnt_d = blk_cnt_q;
        hide_d    = hide_q;
        if (slot_end) begin
            idx_d = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
        end
        if (frame_end) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                hide_d    = ~hide_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    // Constant divide by 10 on a registered snapshot; stable for a whole frame.
    always_comb begin
        floor_val = 32'(snap_floor_q);
        units     = 4'(floor_val % 32'd10);
        tens      = 4'((floor_val / 32'd10) % 32'd10);
        cd_glyph  = (snap_cd_q == 4'd0) ? 8'h00 : ((snap_cd_q < 4'd10) ? seg7(snap_cd_q) : 8'h40);
        glyph     = 8'h00;
        if (idx_q == IDX_W'(3)) begin
            glyph = (floor_val >= 32'd100) ? 8'h40 : ((tens == 4'd0) ? 8'h00 : seg7(tens));
        end else if (idx_q == IDX_W'(2)) begin
            glyph = (floor_val >= 32'd100) ? 8'h40 : seg7(units);
        end else if (idx_q == IDX_W'(1)) begin
            if (hide_q && snap_blink_q && (snap_dir_q == 2'b01 || snap_dir_q == 2'b10)) begin
                glyph = 8'h00;
            end else begin
                case (snap_dir_q)
                    2'b00:   glyph = 8'h3F;
                    2'b01:   glyph = 8'h63;
                    2'b10:   glyph = 8'h5C;
                    default: glyph = 8'h40;
                endcase
            end
        end else if (idx_q == '0) begin
            glyph = cd_glyph | {snap_door_q, 7'b0};
        end
    end

    always_comb begin
        com_lo = '1;
        if (!blank) begin
            com_lo[idx_q] = 1'b0;
        end
        com_d  = COM_ACTIVE_LOW ? com_lo : ~com_lo;
        data_d = blank ? 8'h00 : glyph;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= IDX_LAST;
            blk_cnt_q    <= '0;
            hide_q       <= 1'b0;
            snap_floor_q <= '0;
            snap_dir_q   <= 2'b00;
            snap_cd_q    <= 4'd0;
            snap_door_q  <= 1'b0;
            snap_blink_q <= 1'b0;
            com_q        <= COM_OFF;
            data_q       <= 8'h00;
            tick_q       <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            hide_q    <= hide_d;
            com_q     <= com_d;
            data_q    <= data_d;
            tick_q    <= frame_end;
            if (frame_end) begin
                snap_floor_q <= floor_cur;
                snap_dir_q   <= dir;
                snap_cd_q    <= countdown;
                snap_door_q  <= door_open;
                snap_blink_q <= blink_en;
            end
        end
    end

    assign fnd_com    = com_q;
    assign fnd_data   = data_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: time-indexed reference model plus directed and random scenarios.
module tb_fnd_scan_ctrl;
    localparam int ND = 4;
    localparam int PS = 4;
    localparam int BC = 1;
    localparam int BF = 2;
    localparam int FR = ND * PS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] floor_cur = '0;
    logic [1:0] dir = '0;
    logic [3:0] countdown = '0;
    logic       door_open = 1'b0;
    logic       blink_en = 1'b0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;
    logic       frame_tick;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(
        .NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_CYC(BC), .BLINK_FRAMES(BF),
        .FLOOR_W(7), .COM_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .floor_cur(floor_cur), .dir(dir), .countdown(countdown),
        .door_open(door_open), .blink_en(blink_en),
        .fnd_com(fnd_com), .fnd_data(fnd_data), .frame_tick(frame_tick)
    );

    // Reference: cycle k since reset decides slot/digit/frame; snapshot = inputs at end of previous frame.
    int         k = 0;
    int         m_floor = 0, m_dir = 0, m_cd = 0;
    bit         m_door = 0, m_blink = 0;
    logic [3:0] exp_com = 4'hF;
    logic [7:0] exp_data = 8'h00;
    logic       exp_tick = 1'b0;
    logic [7:0] seen [ND];

    function automatic logic [7:0] ref_seg(input int v);
        case (v)
            0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
            4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h27;
            8: return 8'h7F; 9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ref_glyph(input int digit, input int frame);
        bit hidden;
        hidden = ((frame / BF) % 2) == 1;
        case (digit)
            3: return (m_floor >= 100) ? 8'h40 : ((m_floor / 10 == 0) ? 8'h00 : ref_seg(m_floor / 10));
            2: return (m_floor >= 100) ? 8'h40 : ref_seg(m_floor % 10);
            1: begin
                if (hidden && m_blink && (m_dir == 1 || m_dir == 2)) return 8'h00;
                case (m_dir)
                    0: return 8'h3F;
                    1: return 8'h63;
                    2: return 8'h5C;
                    default: return 8'h40;
                endcase
            end
            0: return ((m_cd == 0) ? 8'h00 : ((m_cd < 10) ? ref_seg(m_cd) : 8'h40)) | (m_door ? 8'h80 : 8'h00);
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        int         pos, digit;
        logic [3:0] oh;
        if (rst) begin
            k <= 0;
            exp_com <= 4'hF; exp_data <= 8'h00; exp_tick <= 1'b0;
            m_floor <= 0; m_dir <= 0; m_cd <= 0; m_door <= 0; m_blink <= 0;
        end else begin
            pos   = k % FR;
            digit = ND - 1 - pos / PS;
            if ((pos % PS) < BC) begin
                exp_com  <= 4'hF;
                exp_data <= 8'h00;
            end else begin
                oh = 4'hF;
                oh[digit] = 1'b0;
                exp_com  <= oh;
                exp_data <= ref_glyph(digit, k / FR);
            end
            exp_tick <= (pos == FR - 1);
            if (pos == FR - 1) begin
                m_floor <= int'(floor_cur); m_dir <= int'(dir); m_cd <= int'(countdown);
                m_door <= door_open; m_blink <= blink_en;
            end
            k <= k + 1;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_chk++;
            if (fnd_com !== 4'hF || fnd_data !== 8'h00 || frame_tick !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: got com=%b data=%h tick=%b, want com=1111 data=00 tick=0", fnd_com, fnd_data, frame_tick);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < FR; c++) begin
            @(negedge clk);
            n_chk++;
            if ({fnd_com, fnd_data, frame_tick} !== {exp_com, exp_data, exp_tick}) begin
                n_bad++;
                $display("FAIL first_frame k=%0d: got com=%b data=%h tick=%b, want com=%b data=%h tick=%b", k, fnd_com, fnd_data, frame_tick, exp_com, exp_data, exp_tick);
            end
            for (int i = 0; i < ND; i++) if (!exp_com[i]) seen[i] = fnd_data;
        end
        n_chk++;
        if ({seen[3], seen[2], seen[1], seen[0]} !== 32'h003F3F00) begin
            n_bad++;
            $display("FAIL first_frame_glyphs: got %h %h %h %h, want 00 3F 3F 00", seen[3], seen[2], seen[1], seen[0]);
        end
    endtask

    task automatic test_snapshot();
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            n_chk++;
            if ({fnd_com, fnd_data, frame_tick} !== {exp_com, exp_data, exp_tick}) begin
                n_bad++;
                $display("FAIL snapshot k=%0d: got com=%b data=%h tick=%b, want com=%b data=%h tick=%b", k, fnd_com, fnd_data, frame_tick, exp_com, exp_data, exp_tick);
            end
            for (int i = 0; i < ND; i++) if (!exp_com[i]) seen[i] = fnd_data;
            if (c == 5) begin
                floor_cur = 7'd12; dir = 2'b01; blink_en = 1'b0;
            end
            if (c == FR - 1) begin
                n_chk++;
                if ({seen[3], seen[2], seen[1], seen[0]} !== 32'h003F3F00) begin
                    n_bad++;
                    $display("FAIL mid_frame_unchanged: got %h %h %h %h, want 00 3F 3F 00", seen[3], seen[2], seen[1], seen[0]);
                end
            end
        end
        n_chk++;
        if ({seen[3], seen[2], seen[1], seen[0]} !== 32'h065B6300) begin
            n_bad++;
            $display("FAIL floor12_frame: got %h %h %h %h, want 06 5B 63 00", seen[3], seen[2], seen[1], seen[0]);
        end
    endtask

    task automatic test_floor_edges();
        logic [6:0]  fl   [2] = '{7'd7, 7'd100};
        logic [15:0] want [2] = '{16'h0027, 16'h4040};
        for (int t = 0; t < 2; t++) begin
            floor_cur = fl[t];
            for (int c = 0; c < 2 * FR; c++) begin
                @(negedge clk);
                n_chk++;
                if ({fnd_com, fnd_data, frame_tick} !== {exp_com, exp_data, exp_tick}) begin
                    n_bad++;
                    $display("FAIL floor_edge k=%0d: got com=%b data=%h tick=%b, want com=%b data=%h tick=%b", k, fnd_com, fnd_data, frame_tick, exp_com, exp_data, exp_tick);
                end
                for (int i = 0; i < ND; i++) if (!exp_com[i]) seen[i] = fnd_data;
            end
            n_chk++;
            if ({seen[3], seen[2]} !== want[t]) begin
                n_bad++;
                $display("FAIL floor_digits floor=%0d: got %h %h, want %h", fl[t], seen[3], seen[2], want[t]);
            end
        end
    endtask

    task automatic test_countdown();
        logic [3:0] cd   [4] = '{4'd3, 4'd12, 4'd0, 4'd0};
        logic       dp   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] want [4] = '{8'hCF, 8'hC0, 8'h80, 8'h00};
        for (int t = 0; t < 4; t++) begin
            countdown = cd[t]; door_open = dp[t];
            for (int c = 0; c < 2 * FR; c++) begin
                @(negedge clk);
                n_chk++;
                if ({fnd_com, fnd_data, frame_tick} !== {exp_com, exp_data, exp_tick}) begin
                    n_bad++;
                    $display("FAIL countdown k=%0d: got com=%b data=%h tick=%b, want com=%b data=%h tick=%b", k, fnd_com, fnd_data, frame_tick, exp_com, exp_data, exp_tick);
                end
                for (int i = 0; i < ND; i++) if (!exp_com[i]) seen[i] = fnd_data;
            end
            n_chk++;
            if (seen[0] !== want[t]) begin
                n_bad++;
                $display("FAIL digit0 cd=%0d door=%0b: got %h, want %h", cd[t], dp[t], seen[0], want[t]);
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] d1 [9];
        int n5c = 0, n00 = 0, n3f = 0;
        dir = 2'b10; blink_en = 1'b1;
        for (int f = 0; f < 9; f++) begin
            for (int c = 0; c < FR; c++) begin
                @(negedge clk);
                n_chk++;
                if ({fnd_com, fnd_data, frame_tick} !== {exp_com, exp_data, exp_tick}) begin
                    n_bad++;
                    $display("FAIL blink k=%0d: got com=%b data=%h tick=%b, want com=%b data=%h tick=%b", k, fnd_com, fnd_data, frame_tick, exp_com, exp_data, exp_tick);
                end
                for (int i = 0; i < ND; i++) if (!exp_com[i]) seen[i] = fnd_data;
            end
            d1[f] = seen[1];
        end
        for (int f = 1; f < 9; f++) begin
            if (d1[f] === 8'h5C) n5c++;
            if (d1[f] === 8'h00) n00++;
        end
        n_chk++;
        if (n5c != 4 || n00 != 4 || d1[1] === d1[3] || d1[1] !== d1[5]) begin
            n_bad++;
            $display("FAIL blink_pattern: got shown=%0d hidden=%0d f1=%h f3=%h f5=%h, want 4/4 with 2-frame halves", n5c, n00, d1[1], d1[3], d1[5]);
        end
        dir = 2'b00;
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < FR; c++) begin
                @(negedge clk);
                n_chk++;
                if ({fnd_com, fnd_data, frame_tick} !== {exp_com, exp_data, exp_tick}) begin
                    n_bad++;
                    $display("FAIL blink_idle k=%0d: got com=%b data=%h tick=%b, want com=%b data=%h tick=%b", k, fnd_com, fnd_data, frame_tick, exp_com, exp_data, exp_tick);
                end
                for (int i = 0; i < ND; i++) if (!exp_com[i]) seen[i] = fnd_data;
            end
            if (f > 0 && seen[1] === 8'h3F) n3f++;
        end
        n_chk++;
        if (n3f != 4) begin
            n_bad++;
            $display("FAIL idle_steady: got %0d frames of 3F, want 4", n3f);
        end
    endtask

    task automatic test_reset_mid();
        floor_cur = 7'd42; dir = 2'b01; countdown = 4'd5; door_open = 1'b1; blink_en = 1'b1;
        for (int c = 0; c < FR + 10; c++) begin
            @(negedge clk);
            n_chk++;
            if ({fnd_com, fnd_data, frame_tick} !== {exp_com, exp_data, exp_tick}) begin
                n_bad++;
                $display("FAIL pre_reset k=%0d: got com=%b data=%h tick=%b, want com=%b data=%h tick=%b", k, fnd_com, fnd_data, frame_tick, exp_com, exp_data, exp_tick);
            end
        end
        n_chk++;
        if (fnd_com !== 4'b1101) begin
            n_bad++;
            $display("FAIL digit1_active_before_reset: got com=%b, want 1101", fnd_com);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (fnd_com !== 4'hF || fnd_data !== 8'h00 || frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got com=%b data=%h tick=%b, want com=1111 data=00 tick=0", fnd_com, fnd_data, frame_tick);
        end
        rst = 1'b0;
        for (int c = 0; c < FR; c++) begin
            @(negedge clk);
            n_chk++;
            if ({fnd_com, fnd_data, frame_tick} !== {exp_com, exp_data, exp_tick}) begin
                n_bad++;
                $display("FAIL post_reset k=%0d: got com=%b data=%h tick=%b, want com=%b data=%h tick=%b", k, fnd_com, fnd_data, frame_tick, exp_com, exp_data, exp_tick);
            end
            for (int i = 0; i < ND; i++) if (!exp_com[i]) seen[i] = fnd_data;
        end
        n_chk++;
        if ({seen[3], seen[2], seen[1], seen[0]} !== 32'h003F3F00) begin
            n_bad++;
            $display("FAIL cleared_snapshot: got %h %h %h %h, want 00 3F 3F 00", seen[3], seen[2], seen[1], seen[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 24 * FR; c++) begin
            @(negedge clk);
            n_chk++;
            if ({fnd_com, fnd_data, frame_tick} !== {exp_com, exp_data, exp_tick}) begin
                n_bad++;
                $display("FAIL random k=%0d: got com=%b data=%h tick=%b, want com=%b data=%h tick=%b", k, fnd_com, fnd_data, frame_tick, exp_com, exp_data, exp_tick);
            end
            if ($urandom_range(7) == 0) begin
                floor_cur = 7'($urandom_range(127));
                dir       = 2'($urandom_range(3));
                countdown = 4'($urandom_range(15));
                door_open = 1'($urandom_range(1));
                blink_en  = 1'($urandom_range(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_floor_edges();
        test_countdown();
        test_blink();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
- Parametrised 7-segment scan controller for the elevator display. Successor to the fixed 4-digit, state-decoded display driver.
- Takes the current floor as a binary value, a direction code, a door-countdown value and door status, and drives NUM_DIGITS common-multiplexed digits.
- Adds a programmable slot prescaler, anti-ghost blanking, frame-synchronous input snapshot, and a blinking direction indicator.
- Sits between the elevator controller FSM and the board FND pins.

Parameters:
- NUM_DIGITS, 4: digits scanned; must be >= 4. Digits 4..NUM_DIGITS-1 are always blank.
- PRESCALE, 50000: clocks per digit slot; must be >= 2.
- BLANK_CYC, 2: clocks at the start of each slot with all commons inactive; must be < PRESCALE.
- BLINK_FRAMES, 64: full scan frames per blink half-period; must be >= 1.
- FLOOR_W, 7: width of floor_cur.
- COM_ACTIVE_LOW, 1: 1 = selected common driven 0; 0 = selected common driven 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- floor_cur  in  FLOOR_W  current floor, binary
- dir  in  2  00 idle, 01 up, 10 down, 11 fault
- countdown  in  4  door countdown; 0 = blank
- door_open  in  1  lights the decimal point on digit 0
- blink_en  in  1  enables direction blinking while moving
- fnd_com  out  NUM_DIGITS  digit commons, one-hot per COM_ACTIVE_LOW
- fnd_data  out  8  segments {dp,g,f,e,d,c,b,a}, active-high
- frame_tick  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset (rst=1 at a clock edge), next cycle:
  - fnd_com all inactive (4'b1111 for the defaults); fnd_data=8'h00; frame_tick=0.
  - Slot counter cnt=0; digit index idx=NUM_DIGITS-1.
  - Blink frame counter=0; blink phase=visible.
  - Snapshot registers cleared to floor 0, dir 00, countdown 0, door_open 0, blink_en 0.
  - Reset mid-operation aborts the scan immediately; no partial state survives.
- Scan:
  - cnt increments every clock.
  - At cnt==PRESCALE-1: cnt->0 and idx decrements, wrapping from 0 to NUM_DIGITS-1.
  - Scan order is MSB digit first.
  - A frame is NUM_DIGITS*PRESCALE clocks.
- Frame boundary (cnt==PRESCALE-1 and idx==0):
  - Snapshot floor_cur, dir, countdown, door_open and blink_en.
  - Assert frame_tick for one cycle on the next cycle (cnt==0, idx==NUM_DIGITS-1).
  - Input changes mid-frame are never displayed until the following frame.
- Output timing:
  - fnd_com and fnd_data are registered; the value in cycle t+1 reflects cnt/idx in cycle t (1-cycle latency).
  - When cnt < BLANK_CYC: commons all inactive and fnd_data=8'h00.
  - Otherwise: common idx active, all others inactive, and fnd_data = glyph for digit idx.
- Glyphs (active-high):
  - Digits 0-9: 3F 06 5B 4F 66 6D 7D 27 7F 6F.
  - Dash 40, blank 00.
  - Top square 63, bottom square 5C, large square 3F.
- Digit map, from the snapshot:
  - Digit 3 = floor tens; blank when tens is 0.
  - Digit 2 = floor units.
  - If floor >= 100, digits 3 and 2 both show dash.
  - Digit 1 = direction: 00->3F, 01->63, 10->5C, 11->40.
  - Digit 0 = countdown: 0 -> blank, 1..9 -> digit, 10..15 -> dash. The dp bit (bit 7) is OR'd in when door_open=1, including when the countdown is blank.
- Decimal conversion: combinational divide/modulo by 10 on the snapshot. No multi-cycle converter is used.
- Blink:
  - The frame counter increments at each frame boundary.
  - At BLINK_FRAMES-1 it clears and the phase toggles.
  - When the phase is hidden, snapshot blink_en=1 and snapshot dir is 01 or 10, digit 1 shows 00. In every other case digit 1 shows its normal glyph.
  - The blink counter runs regardless of dir.
- COM_ACTIVE_LOW=0: fnd_com is the bitwise inverse of the active-low pattern, including the reset and blank values (all 0).

Test Plan (NUM_DIGITS=4, PRESCALE=4, BLANK_CYC=1, BLINK_FRAMES=2, COM_ACTIVE_LOW=1):
- Reset 3 cycles, release -> fnd_com=1111, fnd_data=00. Each 4-cycle slot shows 1 cycle of 1111 then 3 cycles of 0111/1011/1101/1110 in order. First frame: digit3=00, digit2=3F, digit1=3F, digit0=00. frame_tick every 16 cycles.
- floor_cur=12, dir=01, blink_en=0 applied mid-frame -> the current frame is unchanged. Next frame: 0111:06, 1011:5B, 1101:63, 1110:00.
- floor_cur=7 -> digit3=00, digit2=27. floor_cur=100 -> digit3=40, digit2=40.
- dir=10, blink_en=1 -> digit1 shows 5C for 2 frames, then 00 for 2 frames, repeating. Set dir=00 -> digit1 is steady 3F in both phases.
- countdown=3, door_open=1 -> digit0=CF. countdown=12 -> C0. countdown=0, door_open=0 -> 00.
- Assert rst during the active portion of digit 1 -> next cycle fnd_com=1111, fnd_data=00, frame_tick=0. Scan restarts at digit 3 with the cleared snapshot.
